// File: rtl/dmem_pkg.sv
// Shared types and constants for the handshaked data-memory responder.
package dmem_pkg;

    // Wait-state counter width; WAIT_CYCLES must fit (0..15).
    localparam int CNT_W           = 4;
    localparam int DEF_WAIT_CYCLES = 2;
    localparam int DEF_ADDR_WIDTH  = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // A word access is misaligned whenever either low byte-address bit is set.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// CPU data-bus between the MEM stage (master) and the data memory (slave).
interface dmem_responder_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        ack;
    logic        busy;
    logic        err;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, busy, err
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, busy, err
    );

endinterface

// File: rtl/dmem_ram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// Each byte lane is its own array so every lane maps cleanly onto block RAM.
module dmem_ram_be #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            be,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];
            logic [7:0] rd_lane_q;

            // Byte-lane write; contents are never cleared by reset.
            always_ff @(posedge clk) begin
                if (en && we && be[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            // Read register only updates on loads, so it holds across stores.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd_lane_q <= 8'h00;
                end else if (en && !we) begin
                    rd_lane_q <= lane_mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_lane_q;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: accepts one request, waits WAIT_CYCLES, then performs a
// byte-enabled word access and answers with a one-cycle ack (err if misaligned).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    // Only the byte address bits that select a word (plus the two alignment
    // bits) matter; higher bits alias.
    localparam int AB = ADDR_WIDTH + 2;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [AB-1:0]      addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d;
    logic               err_q, err_d;

    // Fields used by the access edge: straight from the bus when the access
    // happens on the acceptance edge (zero wait states), otherwise latched.
    logic               acc_we;
    logic [AB-1:0]      acc_addr;
    logic [31:0]        acc_wdata;
    logic [3:0]         acc_be;
    logic               access;
    logic               acc_mis;
    logic               ram_en;
    logic [31:0]        ram_rdata;

    // Access field selection.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = bus.we;
            acc_addr  = bus.addr[AB-1:0];
            acc_wdata = bus.wdata;
            acc_be    = bus.be;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    // Next-state, latch and response computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr[AB-1:0];
                    wdata_d = bus.wdata;
                    be_d    = bus.be;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        access  = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    access  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // req is ignored here, so the earliest next acceptance is the
                // edge after we return to IDLE.
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        if (access) begin
            ack_d = 1'b1;
            err_d = acc_mis;
        end
    end

    assign acc_mis = is_misaligned(acc_addr[1:0]);

    // Gated by reset so a request pending while reset is held cannot write.
    assign ram_en = access && !acc_mis && reset;

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    dmem_ram_be #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .en    (ram_en),
        .we    (acc_we),
        .addr  (acc_addr[AB-1:2]),
        .wdata (acc_wdata),
        .be    (acc_be),
        .rdata (ram_rdata)
    );

    assign bus.rdata = ram_rdata;
    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a word-array reference model.
module tb_dmem_responder;

    localparam int AW    = 6;
    localparam int W     = 2;
    localparam int DEPTH = 2 ** AW;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_responder_if bus ();

    dmem_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] ref_rdata;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    // One complete transaction; the DUT must be idle on entry.
    task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit scramble, input string tag);
        int cyc;
        bit mis;
        int wi;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        bus.be    = b;
        @(posedge clk);
        #1;
        chk({tag, "/busy_accept"}, 32'(bus.busy), 32'd1);
        if (scramble) begin
            bus.we    = 1'($urandom);
            bus.addr  = $urandom;
            bus.wdata = $urandom;
            bus.be    = 4'($urandom);
        end
        cyc = 0;
        while (bus.ack !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "/latency"}, 32'(cyc), 32'(W));
        mis = (a % 4) != 0;
        wi  = widx(a);
        chk({tag, "/err"}, 32'(bus.err), 32'(mis));
        if (!mis) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) ref_mem[wi][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                ref_rdata = ref_mem[wi];
            end
        end
        chk({tag, "/rdata"}, bus.rdata, ref_rdata);
        $display("txn %-10s we=%0d addr=%h wdata=%h be=%b -> err=%0d rdata=%h lat=%0d",
                 tag, w, a, d, b, bus.err, bus.rdata, cyc);
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "/ack_off"}, 32'(bus.ack), 32'd0);
        chk({tag, "/busy_off"}, 32'(bus.busy), 32'd0);
        chk({tag, "/err_off"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        int          ack_at[$];
        int          acc_at[$];
        bit          prev_busy;
        logic [31:0] old_word;
        logic [31:0] ra;

        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.be    = '0;
        ref_rdata = '0;

        // Reset, then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst/ack", 32'(bus.ack), 32'd0);
        chk("rst/busy", 32'(bus.busy), 32'd0);
        chk("rst/err", 32'(bus.err), 32'd0);
        chk("rst/rdata", bus.rdata, 32'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("idle/ack", 32'(bus.ack), 32'd0);
        end

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++)
            access(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0, "init");

        // Store then load.
        access(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "st10");
        access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "ld10");
        chk("ld10/const", bus.rdata, 32'hDEADBEEF);

        // Partial byte-enable store.
        access(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, "st_be");
        access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "ld_be");
        chk("ld_be/const", bus.rdata, 32'hDE22BE44);

        // Empty byte enable still acks and changes nothing.
        access(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 1'b0, "st_be0");

        // Misaligned store, then alias through the upper address bits.
        access(1'b1, 32'h13, 32'hFFFFFFFF, 4'hF, 1'b0, "mis_st");
        access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, "ld_mis");
        chk("ld_mis/const", bus.rdata, 32'hDE22BE44);
        access(1'b0, 32'h110, 32'h0, 4'h0, 1'b0, "ld_wrap");
        chk("ld_wrap/const", bus.rdata, 32'hDE22BE44);

        // Back-to-back loads with req held across the ack.
        @(negedge clk);
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 32'h10;
        prev_busy = 1'b0;
        for (int e = 0; e < 30 && ack_at.size() < 2; e++) begin
            @(posedge clk);
            #1;
            if (bus.busy && !prev_busy) acc_at.push_back(e);
            prev_busy = bus.busy;
            if (bus.ack) ack_at.push_back(e);
        end
        bus.req = 1'b0;
        ref_rdata = ref_mem[widx(32'h10)];
        chk("b2b/acks", 32'(ack_at.size()), 32'd2);
        chk("b2b/accepts", 32'(acc_at.size()), 32'd2);
        if (acc_at.size() == 2)
            chk("b2b/accept_gap", 32'(acc_at[1] - acc_at[0]), 32'(W + 2));
        if (ack_at.size() == 2) begin
            chk("b2b/ack1", 32'(ack_at[0]), 32'(W));
            chk("b2b/ack_gap", 32'(ack_at[1] - ack_at[0]), 32'(W + 2));
        end
        chk("b2b/rdata", bus.rdata, ref_rdata);
        $display("txn b2b        acks=%0d accepts=%0d rdata=%h", ack_at.size(), acc_at.size(), bus.rdata);
        @(posedge clk);
        #1;
        chk("b2b/idle_busy", 32'(bus.busy), 32'd0);

        // Reset during the wait states drops the store.
        old_word = ref_mem[widx(32'h24)];
        @(negedge clk);
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = 32'h24;
        bus.wdata = ~old_word;
        bus.be    = 4'hF;
        @(posedge clk);
        #1;
        chk("rstmid/busy_accept", 32'(bus.busy), 32'd1);
        bus.req = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rstmid/busy", 32'(bus.busy), 32'd0);
        chk("rstmid/ack", 32'(bus.ack), 32'd0);
        ref_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        $display("txn rstmid     store to 0x24 interrupted by reset");
        repeat (6) begin
            @(posedge clk);
            #1;
            chk("rstmid/no_ack", 32'(bus.ack), 32'd0);
        end
        chk("rstmid/rdata_clr", bus.rdata, 32'd0);
        access(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, "ld_rstmid");
        chk("ld_rstmid/old", bus.rdata, old_word);

        // Random traffic, with the bus scrambled after each acceptance.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            if ($urandom_range(0, 4) != 0) ra[1:0] = 2'b00;
            access(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom), 1'b1, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
